// File: rtl/dir_input_queue.sv
// rtl/dir_input_queue.sv - debounced direction buttons feeding a legal-turn token FIFO
// Optional DIR_QUEUE_OVERWRITE_EN: a press while full without pop replaces the newest entry.
module dir_input_queue #(
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 14,
  localparam int PW             = $clog2(DEPTH),
  localparam int CW             = $clog2(DEPTH) + 1
) (
  input  logic          hwclk,
  input  logic          reset,
  input  logic          sync_clear,
  input  logic [3:0]    dir_pb,
  input  logic          pop,
  output logic          dir_valid,
  output logic [1:0]    dir_head,
  output logic [1:0]    cur_dir,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          drop_pulse
);

  logic [3:0]       sync1, sync2, deb, armed, press_q;
  logic [1:0]       sync_age;
  logic [CNT_W-1:0] cnt [4];

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, next_rd;
  logic [CW-1:0] next_count;
  logic [1:0]    token, ref_dir;
  logic          do_pop, do_push, do_ovw, reject;
`ifdef DIR_QUEUE_OVERWRITE_EN
  logic [1:0]    second_dir;
`endif

  assign dir_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));

  // A button is armed only once it has been seen released after reset, so a
  // level held through reset never turns into a press.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1 <= '0; sync2 <= '0; deb <= '0; armed <= '0; press_q <= '0; sync_age <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (sync_clear) begin
      sync1 <= '0; sync2 <= '0; deb <= '0; armed <= '0; press_q <= '0; sync_age <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= dir_pb;
      sync2 <= sync1;
      if (sync_age != 2'd2) sync_age <= sync_age + 2'd1;
      for (int i = 0; i < 4; i++) begin
        armed[i]   <= armed[i] | ((sync_age == 2'd2) & ~sync2[i]);
        press_q[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          cnt[i]     <= '0;
          press_q[i] <= sync2[i] & armed[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    token = 2'b01;
    if (press_q[3])      token = 2'b00;
    else if (press_q[2]) token = 2'b11;
    else if (press_q[1]) token = 2'b10;
    ref_dir = (count == '0) ? cur_dir : mem[wr_ptr - PW'(1)];
    do_pop  = pop && dir_valid;
    do_push = 1'b0;
    do_ovw  = 1'b0;
    reject  = 1'b0;
`ifdef DIR_QUEUE_OVERWRITE_EN
    second_dir = mem[wr_ptr - PW'(2)];
`endif
    if (press_q != 4'd0) begin
      if ((press_q & (press_q - 4'd1)) != 4'd0) begin
        reject = 1'b1;
      end else if (!full || do_pop) begin
        do_push = (token != ref_dir) && (token != (ref_dir ^ 2'b10));
        reject  = !do_push;
      end else begin
        reject = 1'b1;
`ifdef DIR_QUEUE_OVERWRITE_EN
        do_ovw = (token != second_dir) && (token != (second_dir ^ 2'b10));
`endif
      end
    end
    next_rd    = do_pop ? rd_ptr + PW'(1) : rd_ptr;
    next_count = count + CW'(do_push) - CW'(do_pop);
  end

  // dir_head is loaded with whatever will sit at the head after this edge,
  // bypassing the write when the pushed token lands at the head slot.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0; cur_dir <= 2'b01; dir_head <= 2'b00; drop_pulse <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
    end else if (sync_clear) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0; cur_dir <= 2'b01; dir_head <= 2'b00; drop_pulse <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
    end else begin
      drop_pulse <= reject;
      count      <= next_count;
      if (do_push) begin
        mem[wr_ptr] <= token;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_ovw) mem[wr_ptr - PW'(1)] <= token;
      if (do_pop) begin
        rd_ptr  <= next_rd;
        cur_dir <= dir_head;
      end
      if (do_push && next_rd == wr_ptr)                dir_head <= token;
      else if (do_ovw && next_rd == wr_ptr - PW'(1))   dir_head <= token;
      else if (next_count != '0)                       dir_head <= mem[next_rd];
    end
  end

endmodule
